// File: rtl/booth_pp_accum_pkg.sv
// Shared sizing constants and FSM encoding for the Booth
// partial-product accumulator.
package booth_pp_accum_pkg;

  localparam int WIDTH  = 14;
  localparam int NUM_PP = 8;
  localparam int PW     = 2 * WIDTH + 2;
  localparam int IW     = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

endpackage

// File: rtl/booth_pp_accum_if.sv
// Beat-in / product-out handshake bundle for the Booth
// partial-product accumulator.
interface booth_pp_accum_if #(
  parameter int WIDTH  = booth_pp_accum_pkg::WIDTH,
  parameter int NUM_PP = booth_pp_accum_pkg::NUM_PP
);

  localparam int PW = 2 * WIDTH + 2;
  localparam int IW = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  logic [WIDTH:0]  pp_in;
  logic            comp_in;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   prod;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   beat_idx;

  modport slave (
    input  pp_in,
    input  comp_in,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output prod,
    output out_valid,
    output beat_idx
  );

  modport master (
    output pp_in,
    output comp_in,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  prod,
    input  out_valid,
    input  beat_idx
  );

endinterface

// File: rtl/booth_pp_accum_align.sv
// Sign-extends one partial product, folds in its completion
// bit and aligns it to radix-4 weight 4^beat_idx.
module booth_pp_align #(
  parameter int WIDTH  = booth_pp_accum_pkg::WIDTH,
  parameter int NUM_PP = booth_pp_accum_pkg::NUM_PP
) (
  input  logic [WIDTH:0]                     pp_in,
  input  logic                               comp_in,
  input  logic [((NUM_PP > 1) ?
                 $clog2(NUM_PP) : 1)-1:0]    beat_idx,
  output logic [2*WIDTH+1:0]                 addend
);

  localparam int PW = 2 * WIDTH + 2;
  localparam int IW = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  logic [PW-1:0] ext;
  logic [PW-1:0] cin;
  logic [IW:0]   sh;

  always_comb begin
    ext = {{(PW-WIDTH-1){pp_in[WIDTH]}}, pp_in};
    cin = PW'(comp_in);
    sh  = {beat_idx, 1'b0};
    // both terms share the same weight, so add before shifting
    addend = (ext + cin) << sh;
  end

endmodule

// File: rtl/booth_pp_accum.sv
// Accumulates NUM_PP radix-4 Booth partial products into one
// PW-bit product and holds it until the consumer takes it.
module booth_pp_accum #(
  parameter int WIDTH  = booth_pp_accum_pkg::WIDTH,
  parameter int NUM_PP = booth_pp_accum_pkg::NUM_PP
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_pp_accum_if.slave   bus
);

  import booth_pp_accum_pkg::*;

  localparam int LPW = 2 * WIDTH + 2;
  localparam int LIW = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  state_t           state;
  state_t           state_nx;
  logic [LPW-1:0]   acc;
  logic [LPW-1:0]   addend;
  logic [LIW-1:0]   idx;
  logic             live;
  logic             last;
  logic             take;
  logic             drain;

  booth_pp_align #(
    .WIDTH  (WIDTH),
    .NUM_PP (NUM_PP)
  ) u_align (
    .pp_in    (bus.pp_in),
    .comp_in  (bus.comp_in),
    .beat_idx (idx),
    .addend   (addend)
  );

  assign last  = (idx == LIW'(NUM_PP - 1));
  assign take  = bus.in_valid & bus.in_ready;
  assign drain = bus.out_valid & bus.out_ready;

  // live holds in_ready low until the first edge out of reset
  assign bus.in_ready  = live & (state == ACC);
  assign bus.out_valid = (state == OUT);
  assign bus.prod      = acc;
  assign bus.beat_idx  = idx;

  always_comb begin
    state_nx = state;
    unique case (state)
      ACC: if (take && last) state_nx = OUT;
      OUT: if (drain)        state_nx = ACC;
      default:               state_nx = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc   <= '0;
      idx   <= '0;
      live  <= 1'b0;
    end else begin
      live  <= 1'b1;
      state <= state_nx;
      if (take) begin
        acc <= acc + addend;
        idx <= last ? '0 : idx + LIW'(1);
      end else if (drain) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Directed + random bench: Booth-recodes operand pairs and
// compares the accumulated product with a*b mod 2^30.
module tb_booth_pp_accum;

  localparam int W  = 14;
  localparam int NP = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  logic [W:0] pp_q [NP];
  logic       cm_q [NP];

  booth_pp_accum_if #(.WIDTH(W), .NUM_PP(NP)) bus ();

  booth_pp_accum #(.WIDTH(W), .NUM_PP(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Radix-4 Booth recoding of b, each digit times a.
  task automatic booth(input logic signed [W-1:0] a,
                       input logic signed [2*NP-1:0] b);
    for (int i = 0; i < NP; i++) begin
      int d;
      int v;
      logic [31:0] t;
      logic y0;
      y0 = (i == 0) ? 1'b0 : b[2*i-1];
      d  = -2 * int'(b[2*i+1]) + int'(b[2*i]) + int'(y0);
      v  = int'(a) * ((d < 0) ? -d : d);
      t  = v;
      pp_q[i] = (d < 0) ? ~t[W:0] : t[W:0];
      cm_q[i] = (d < 0);
    end
  endtask

  task automatic send_beat(input logic [W:0] pp, input logic cm);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.pp_in    = pp;
    bus.comp_in  = cm;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi,
                            input int stall);
    for (int i = lo; i < hi; i++) begin
      repeat ($urandom_range(0, stall)) @(negedge clk);
      send_beat(pp_q[i], cm_q[i]);
    end
  endtask

  task automatic expect_done(input logic signed [W-1:0] a,
                             input logic signed [2*NP-1:0] b,
                             input string tag);
    longint p;
    logic [63:0] pv;
    p  = longint'(a) * longint'(b);
    pv = p;
    @(negedge clk);
    check({tag, "_ov"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_prod"}, 64'(bus.prod), 64'(pv[2*W+1:0]));
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    int errs;
    bus.pp_in = '0;
    bus.comp_in = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;

    #23;
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    check("rst_ov", 64'(bus.out_valid), 64'd0);
    check("rst_prod", 64'(bus.prod), 64'd0);
    check("rst_idx", 64'(bus.beat_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready_lo", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("rel_ready_hi", 64'(bus.in_ready), 64'd1);

    // positive product 3*5
    booth(14'sd3, 16'sd5);
    send_range(0, NP, 0);
    expect_done(14'sd3, 16'sd5, "pos");
    check("pos_lit", 64'(bus.prod), 64'h0F);
    check("pos_rdy", 64'(bus.in_ready), 64'd0);
    drain();

    // negative product 3*-1
    @(negedge clk);
    check("clr_ready", 64'(bus.in_ready), 64'd1);
    check("clr_prod", 64'(bus.prod), 64'd0);
    booth(14'sd3, -16'sd1);
    check("neg_pp0", 64'(pp_q[0]), 64'h7FFC);
    send_range(0, NP, 0);
    expect_done(14'sd3, -16'sd1, "neg");
    check("neg_lit", 64'(bus.prod), 64'h3FFFFFFD);

    // back-pressure with ignored beats
    held = 64'(bus.prod);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.pp_in = 15'($urandom);
      bus.comp_in = 1'b1;
      @(negedge clk);
      check("bp_prod", 64'(bus.prod), held);
      check("bp_ready", 64'(bus.in_ready), 64'd0);
      check("bp_idx", 64'(bus.beat_idx), 64'd0);
    end
    bus.in_valid = 1'b0;
    drain();
    booth(14'sd3, 16'sd5);
    send_range(0, NP, 0);
    expect_done(14'sd3, 16'sd5, "bp_next");
    drain();

    // stalls between beats
    send_range(0, NP, 4);
    expect_done(14'sd3, 16'sd5, "stall");
    drain();

    // reset mid-product
    send_range(0, 3, 0);
    @(negedge clk);
    check("mid_idx", 64'(bus.beat_idx), 64'd3);
    check("mid_prod", 64'(bus.prod), 64'h0F);
    rst_n = 1'b0;
    #1;
    check("mid_rst_prod", 64'(bus.prod), 64'd0);
    check("mid_rst_idx", 64'(bus.beat_idx), 64'd0);
    check("mid_rst_rdy", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    booth(14'sd3, -16'sd1);
    send_range(0, NP, 0);
    expect_done(14'sd3, -16'sd1, "after_rst");
    drain();

    // random pairs
    errs = miscompares;
    for (int r = 0; r < 1000; r++) begin
      logic signed [W-1:0] a;
      logic signed [2*NP-1:0] b;
      a = W'($urandom);
      b = (2*NP)'($urandom);
      if (r == 0) a = 14'sh2000;
      if (r == 0) b = 16'sh8000;
      booth(a, b);
      send_range(0, NP, (r % 7 == 0) ? 2 : 0);
      expect_done(a, b, "rand");
      drain();
      if (miscompares - errs > 10) break;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth_pp_accum.md
BOOTH_PP_ACCUM -- requirements
Module: booth_pp_accum

Interface
REQ-001 Parameter WIDTH, default 14, SHALL set the multiplicand width; each partial product is WIDTH+1 bits.
REQ-002 Parameter NUM_PP, default 8, SHALL set the number of radix-4 partial products per product.
REQ-003 Derived constant PW = 2*WIDTH+2 SHALL set the product width (30 at defaults).
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 pp_in  input  WIDTH+1  selected partial product, two's-complement, bitwise-inverted when negative.
REQ-007 comp_in  input  1  negation completion bit; adds 1 at the partial product's LSB weight.
REQ-008 in_valid  input  1  pp_in and comp_in valid this cycle.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 prod  output  PW  completed product, two's-complement.
REQ-011 out_valid  output  1  prod valid.
REQ-012 out_ready  input  1  consumer accepts prod.
REQ-013 beat_idx  output  log2(NUM_PP)  index of the next beat to be accepted.

Function
REQ-014 The block SHALL have two states: ACC (collecting beats) and OUT (holding the result).
REQ-015 In ACC, in_ready SHALL be 1 and out_valid SHALL be 0; in OUT, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 A beat SHALL be accepted only in a cycle where in_valid & in_ready are both 1.
REQ-017 On beat i (i = beat_idx), acc SHALL become acc + (sign-extend(pp_in) << 2i) + (comp_in << 2i), truncated to PW bits.
REQ-018 beat_idx SHALL increment by 1 on every accepted beat.
REQ-019 On the accepted beat with beat_idx = NUM_PP-1:
- state SHALL move to OUT.
- beat_idx SHALL wrap to 0.
- prod SHALL show the final sum on the next cycle (one-cycle latency from the last beat).
REQ-020 In OUT, prod SHALL remain stable until out_valid & out_ready.
REQ-021 On out_valid & out_ready:
- state SHALL return to ACC.
- acc SHALL clear to 0.
- in_ready SHALL become 1 on the following cycle.
REQ-022 A beat presented while in OUT SHALL be ignored and SHALL NOT alter acc.
REQ-023 Cycles with in_valid = 0 in ACC SHALL leave acc and beat_idx unchanged (stalls allowed between beats).
REQ-024 Overflow beyond PW bits SHALL wrap silently; no saturation.
REQ-025 Minimum throughput SHALL be one product per NUM_PP+1 cycles.

Reset
REQ-026 While rst_n = 0, the following SHALL hold regardless of clk:
- state = ACC.
- acc = 0, prod = 0, beat_idx = 0.
- out_valid = 0.
REQ-027 in_ready SHALL be 0 while rst_n = 0 and SHALL be 1 from the first clk edge after rst_n rises.
REQ-028 Reset asserted mid-product or in OUT SHALL discard all partial state; the next accepted beat SHALL be beat 0.

Structure
REQ-029 WIDTH, NUM_PP, PW and the state encoding SHALL live in the shared FMA package.
REQ-030 Sign-extension and shift-by-2i alignment SHALL be one combinational sub-module, booth_pp_align (inputs pp_in, comp_in, beat_idx; output a PW-bit addend).

Verification (WIDTH=14, NUM_PP=8)
REQ-031 Positive product: multiplicand 3, multiplier 5. Beats pp=3/comp=0, pp=3/comp=0, then six beats pp=0/comp=0 -> prod = 15 (0x0000000F), out_valid after beat 8.
REQ-032 Negative product: multiplicand 3, multiplier -1. Beat0 pp=0x7FFC/comp=1, then seven zero beats -> prod = 0x3FFFFFFD (-3).
REQ-033 Back-pressure: hold out_ready=0 for 5 cycles after completion -> prod stable, in_ready=0; beats offered meanwhile are ignored; with out_ready=1, the next product starts from acc=0.
REQ-034 Stalls: insert random in_valid=0 gaps between the beats of REQ-031 -> prod = 15 unchanged.
REQ-035 Reset mid-product: assert rst_n=0 after beat 3 -> outputs zero immediately; a fresh product of REQ-032 then yields 0x3FFFFFFD.
REQ-036 Random self-check: 1000 random multiplicand/multiplier pairs, Booth-recoded by the bench -> prod equals the signed product modulo 2^30.
